// File: rtl/burst_sdr_fifo.sv
// Burst serial data port: TX/RX byte FIFOs, programmable shift-clock divider,
// synchronised CNT/SP receive and a level interrupt. All state moves on the falling E_CLK edge.

module burst_sdr_fifo_buf #(
  parameter int DEPTH = 4
) (
  input  logic       E_CLK,
  input  logic       RESET_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic [3:0] level,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == 4'(DEPTH);
  assign empty   = cnt_q == '0;
  assign head    = mem_q[rd_q];
  assign level   = cnt_q;
  assign do_pop  = pop && !empty;
  // a push into a full buffer still lands when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + 4'(do_push) - 4'(do_pop);
    end
  end

  always_ff @(negedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(negedge E_CLK) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
endmodule

module burst_sdr_fifo #(
  parameter logic [11:0]      BASE_ADDR  = 12'hFD9,
  parameter int               FIFO_DEPTH = 4,
  parameter int               DIV_W      = 8,
  parameter logic [DIV_W-1:0] DIV_INIT   = DIV_W'(7)
) (
  input  logic        RESET_n,
  input  logic        E_CLK,
  input  logic        RW,
  input  logic        MUX,
  input  logic [15:0] A,
  inout  wire  [7:0]  D,
  inout  wire         CNT,
  inout  wire         SP,
  output logic        IRQ_n
);
  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} tx_st_e;

  tx_st_e           st_q, st_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d, div_q, div_d;
  logic [2:0]       bit_q, bit_d, rbit_q, rbit_d, cs_q, cs_d;
  logic [7:0]       tsh_q, tsh_d, rsh_q, rsh_d;
  logic [1:0]       ss_q, ss_d;
  logic             dir_q, dir_d, rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, ovf_q, ovf_d, irq_q;

  logic       sel, wr_data, wr_ctrl, wr_div, rd_pop, dir_fall, dir_rise, flush, tx_flush;
  logic       tx_pop, rx_push, rise, busy, tx_idle, irq;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head, rd_data, stat;
  logic [3:0] tx_level, rx_level;
  logic       unused_a;

  assign unused_a = ^A[3:2];
  assign sel      = A[15:4] == BASE_ADDR;
  assign wr_data  = sel && !RW && A[1:0] == 2'd0;
  assign wr_ctrl  = sel && !RW && A[1:0] == 2'd1;
  assign wr_div   = sel && !RW && A[1:0] == 2'd2;
  assign rd_pop   = sel &&  RW && A[1:0] == 2'd0;
  assign dir_fall = wr_ctrl && dir_q && !D[6];
  assign dir_rise = wr_ctrl && !dir_q && D[6];
  assign flush    = wr_ctrl && D[4];
  assign tx_flush = flush || dir_fall;

  burst_sdr_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx (
    .E_CLK(E_CLK), .RESET_n(RESET_n), .push(wr_data), .pop(tx_pop), .flush(tx_flush),
    .din(D), .head(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty));

  burst_sdr_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx (
    .E_CLK(E_CLK), .RESET_n(RESET_n), .push(rx_push), .pop(rd_pop), .flush(flush),
    .din({rsh_q[6:0], ss_q[1]}), .head(rx_head), .level(rx_level), .full(rx_full),
    .empty(rx_empty));

  // TX shifter: each half-period reloads from the live divider value
  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    bit_d  = bit_q;
    tsh_d  = tsh_q;
    tx_pop = 1'b0;
    case (st_q)
      ST_IDLE: if (dir_q && !tx_empty) begin
        tx_pop = 1'b1; tsh_d = tx_head; bit_d = '0; hcnt_d = div_q; st_d = ST_LOW;
      end
      ST_LOW: if (hcnt_q == '0) begin
        hcnt_d = div_q; st_d = ST_HIGH;
      end else hcnt_d = hcnt_q - DIV_W'(1);
      ST_HIGH: if (hcnt_q != '0) hcnt_d = hcnt_q - DIV_W'(1);
      else if (bit_q != 3'd7) begin
        tsh_d = {tsh_q[6:0], 1'b0}; bit_d = bit_q + 3'd1; hcnt_d = div_q; st_d = ST_LOW;
      end else if (!tx_empty) begin
        tx_pop = 1'b1; tsh_d = tx_head; bit_d = '0; hcnt_d = div_q; st_d = ST_LOW;
      end else st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (dir_fall) begin
      st_d   = ST_IDLE;
      tx_pop = 1'b0;
    end
  end

  assign cs_d = {cs_q[1:0], CNT};
  assign ss_d = {ss_q[0], SP};
  assign rise = cs_q[1] && !cs_q[2];

  always_comb begin
    rsh_d   = rsh_q;
    rbit_d  = rbit_q;
    rx_push = 1'b0;
    if (!dir_q && rise) begin
      rsh_d   = {rsh_q[6:0], ss_q[1]};
      rbit_d  = rbit_q + 3'd1;
      rx_push = rbit_q == 3'd7;
    end
    if (flush || dir_rise) rbit_d = '0;
  end

  always_comb begin
    dir_d   = dir_q;
    rx_ie_d = rx_ie_q;
    tx_ie_d = tx_ie_q;
    div_d   = div_q;
    ovf_d   = ovf_q;
    if (wr_ctrl) begin
      dir_d   = D[6];
      rx_ie_d = D[1];
      tx_ie_d = D[0];
      if (D[5]) ovf_d = 1'b0;
    end
    if (wr_div) div_d = D[DIV_W-1:0];
    if (rx_push && rx_full && !rd_pop) ovf_d = 1'b1;
  end

  assign busy    = st_q != ST_IDLE;
  assign tx_idle = tx_empty && !busy;
  assign irq     = (rx_ie_q && (!rx_empty || ovf_q)) || (tx_ie_q && tx_idle);
  assign stat    = {irq, dir_q, ovf_q, busy, tx_full, tx_idle, !rx_empty, rx_full};

  always_comb begin
    case (A[1:0])
      2'd0:    rd_data = rx_head;
      2'd1:    rd_data = stat;
      2'd2:    rd_data = 8'(div_q);
      default: rd_data = {tx_level, rx_level};
    endcase
  end

  always_ff @(negedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      st_q <= ST_IDLE; hcnt_q <= '0; bit_q <= '0; tsh_q <= '0;
      rsh_q <= '0; rbit_q <= '0; cs_q <= 3'b111; ss_q <= 2'b11;
      dir_q <= 1'b0; rx_ie_q <= 1'b0; tx_ie_q <= 1'b0; ovf_q <= 1'b0;
      div_q <= DIV_INIT; irq_q <= 1'b0;
    end else begin
      st_q <= st_d; hcnt_q <= hcnt_d; bit_q <= bit_d; tsh_q <= tsh_d;
      rsh_q <= rsh_d; rbit_q <= rbit_d; cs_q <= cs_d; ss_q <= ss_d;
      dir_q <= dir_d; rx_ie_q <= rx_ie_d; tx_ie_q <= tx_ie_d; ovf_q <= ovf_d;
      div_q <= div_d; irq_q <= irq;
    end
  end

  assign IRQ_n = !irq_q;
  assign D     = (sel && RW && !MUX) ? rd_data : 8'bz;
  assign CNT   = (st_q == ST_LOW) ? 1'b0 : 1'bz;
  assign SP    = (st_q != ST_IDLE && !tsh_q[7]) ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_burst_sdr_fifo.sv
// Directed + randomized bench for burst_sdr_fifo: bus tasks, a CNT/SP line monitor
// and queue-based expectations for both transfer directions.
module tb_burst_sdr_fifo;
  localparam logic [15:0] A_DATA = 16'hFD90, A_CTRL = 16'hFD91, A_DIV = 16'hFD92,
                          A_LVL  = 16'hFD93;

  logic        E_CLK = 1'b0, RESET_n = 1'b0, RW = 1'b1, MUX = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  d_drv = 8'h00;
  logic        d_oe = 1'b0, cnt_lo = 1'b0, sp_lo = 1'b0;
  wire  [7:0]  D;
  wire         CNT, SP;
  logic        IRQ_n;
  int          total = 0, bad = 0;

  assign D   = d_oe ? d_drv : 8'hzz;
  assign CNT = cnt_lo ? 1'b0 : 1'bz;
  assign SP  = sp_lo ? 1'b0 : 1'bz;
  pullup (CNT);
  pullup (SP);

  burst_sdr_fifo dut (.RESET_n(RESET_n), .E_CLK(E_CLK), .RW(RW), .MUX(MUX), .A(A), .D(D),
                      .CNT(CNT), .SP(SP), .IRQ_n(IRQ_n));

  always #5 E_CLK = ~E_CLK;

  // line monitor: decodes bytes MSB first on CNT rise, timestamps every edge
  int         cyc = 0, mon_n = 0;
  logic       mon_prev = 1'b1, mon_clr = 1'b0;
  logic [7:0] mon_sh = 8'h00;
  int         rise_t[$], fall_t[$];
  logic [7:0] mon_q[$];

  always @(posedge E_CLK) begin
    cyc      <= cyc + 1;
    mon_prev <= CNT;
    if (mon_clr) begin
      rise_t.delete(); fall_t.delete(); mon_q.delete();
      mon_n <= 0;
    end else begin
      if (mon_prev === 1'b1 && CNT === 1'b0) fall_t.push_back(cyc);
      if (mon_prev === 1'b0 && CNT === 1'b1) begin
        rise_t.push_back(cyc);
        mon_sh <= {mon_sh[6:0], SP};
        if (mon_n == 7) begin
          mon_q.push_back({mon_sh[6:0], SP});
          mon_n <= 0;
        end else mon_n <= mon_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
    @(posedge E_CLK);
    A = addr; RW = 1'b0; MUX = 1'b1; d_drv = data; d_oe = 1'b1;
    @(negedge E_CLK);
    #1 A = 16'h0000; RW = 1'b1; d_oe = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [7:0] data);
    @(posedge E_CLK);
    A = addr; RW = 1'b1; MUX = 1'b0;
    #2 data = D;
    @(negedge E_CLK);
    #1 A = 16'h0000; MUX = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] v;
    bus_rd(addr, v);
    chk(tag, v, exp);
  endtask

  task automatic clr_mon();
    @(posedge E_CLK); mon_clr = 1'b1;
    @(posedge E_CLK); mon_clr = 1'b0;
  endtask

  task automatic wait_fall(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge E_CLK);
      if (CNT === 1'b0) ok = 1;
    end
    chk(tag, ok, 1);
  endtask

  // drive one byte as an external transmitter, 7-cycle bit period
  task automatic send_byte(input logic [7:0] b, input bit watch, output int lat);
    lat = 0;
    for (int i = 7; i >= 0; i--) begin
      @(posedge E_CLK);
      cnt_lo = 1'b1; sp_lo = !b[i];
      repeat (3) @(posedge E_CLK);
      cnt_lo = 1'b0;
      if (i == 0 && watch) begin
        for (int k = 1; k <= 8 && lat == 0; k++) begin
          @(posedge E_CLK);
          if (IRQ_n === 1'b0) lat = k;
        end
      end else repeat (3) @(posedge E_CLK);
    end
    sp_lo = 1'b0;
  endtask

  task automatic chk_tx(input string tag, input logic [7:0] exp_q[$], input int div);
    int viol = 0;
    chk({tag, "_nbytes"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk({tag, "_byte"}, mon_q[i], exp_q[i]);
    chk({tag, "_nrise"}, rise_t.size(), 8 * exp_q.size());
    for (int i = 0; i + 1 < rise_t.size(); i++)
      if (rise_t[i+1] - rise_t[i] != 2 * (div + 1)) viol++;
    chk({tag, "_spacing"}, viol, 0);
    if (rise_t.size() > 0 && fall_t.size() > 0)
      chk({tag, "_lowlen"}, rise_t[0] - fall_t[0], div + 1);
  endtask

  initial begin
    logic [7:0] v, b;
    logic [7:0] exp_q[$];
    logic [7:0] rxm[$];
    int lat, div, n;

    repeat (3) @(posedge E_CLK);
    chk("rst_cnt", CNT, 1'b1);
    chk("rst_sp", SP, 1'b1);
    chk("rst_irq", IRQ_n, 1'b1);
    RESET_n = 1'b1;
    rd_chk("rst_stat", A_CTRL, 8'h04);
    rd_chk("rst_div", A_DIV, 8'h07);
    rd_chk("rst_lvl", A_LVL, 8'h00);
    rd_chk("mirror_stat", 16'hFD95, 8'h04);

    // single byte at the fastest rate
    bus_wr(A_CTRL, 8'h40);
    bus_wr(A_DIV, 8'h00);
    clr_mon();
    bus_wr(A_DATA, 8'hA5);
    wait_fall("a5_start");
    repeat (14) @(posedge E_CLK);
    rd_chk("a5_busy", A_CTRL, 8'h50);
    rd_chk("a5_done", A_CTRL, 8'h44);
    exp_q = '{8'hA5};
    chk_tx("a5", exp_q, 0);

    // fill TX while stopped, overfill, then release as a burst
    bus_wr(A_CTRL, 8'h00);
    bus_wr(A_DIV, 8'h07);
    bus_wr(A_DATA, 8'h12);
    bus_wr(A_DATA, 8'h34);
    bus_wr(A_DATA, 8'h56);
    bus_wr(A_DATA, 8'h78);
    rd_chk("burst_full", A_CTRL, 8'h08);
    bus_wr(A_DATA, 8'h9A);
    rd_chk("burst_lvl", A_LVL, 8'h40);
    clr_mon();
    bus_wr(A_CTRL, 8'h40);
    wait_fall("burst_start");
    repeat (530) @(posedge E_CLK);
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    chk_tx("burst", exp_q, 7);
    if (rise_t.size() == 32 && fall_t.size() > 0)
      chk("burst_span", rise_t[31] - fall_t[0], 504);
    rd_chk("burst_idle", A_CTRL, 8'h44);

    // random bytes at random rates
    for (int r = 0; r < 2; r++) begin
      div = $urandom_range(0, 3);
      bus_wr(A_DIV, 8'(div));
      clr_mon();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_wr(A_DATA, b);
      end
      repeat (48 * (div + 1) + 20) @(posedge E_CLK);
      chk_tx("rnd_tx", exp_q, div);
    end

    // direction change mid-byte aborts the transfer and drops queued TX
    bus_wr(A_DIV, 8'h03);
    bus_wr(A_DATA, 8'h00);
    bus_wr(A_DATA, 8'h00);
    wait_fall("abort_start");
    repeat (9) @(posedge E_CLK);
    chk("abort_cnt_drv", CNT, 1'b0);
    chk("abort_sp_drv", SP, 1'b0);
    bus_wr(A_CTRL, 8'h00);
    @(posedge E_CLK);
    chk("abort_cnt_rel", CNT, 1'b1);
    chk("abort_sp_rel", SP, 1'b1);
    rd_chk("abort_lvl", A_LVL, 8'h00);
    rd_chk("abort_stat", A_CTRL, 8'h04);
    repeat (3) @(posedge E_CLK);
    bus_wr(A_CTRL, 8'h10);

    // receive overflow and stale pop
    for (int i = 0; i < 5; i++) send_byte(8'h3C, 0, lat);
    rd_chk("ovf_lvl", A_LVL, 8'h04);
    rd_chk("ovf_stat", A_CTRL, 8'h27);
    for (int i = 0; i < 4; i++) rd_chk("ovf_pop", A_DATA, 8'h3C);
    rd_chk("ovf_lvl0", A_LVL, 8'h00);
    rd_chk("stale_pop", A_DATA, 8'h3C);
    rd_chk("stale_lvl", A_LVL, 8'h00);
    rd_chk("ovf_sticky", A_CTRL, 8'h24);
    bus_wr(A_CTRL, 8'h20);
    rd_chk("ovf_clr", A_CTRL, 8'h04);

    // random receive against a queue
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        rxm.push_back(b);
        send_byte(b, 0, lat);
      end
      rd_chk("rnd_rx_lvl", A_LVL, 8'(rxm.size()));
      while (rxm.size() > 0) rd_chk("rnd_rx_pop", A_DATA, rxm.pop_front());
    end

    // receive interrupt
    bus_wr(A_CTRL, 8'h02);
    repeat (2) @(posedge E_CLK);
    chk("rxirq_quiet", IRQ_n, 1'b1);
    send_byte(8'h5A, 1, lat);
    chk("rxirq_lat", (lat >= 1 && lat <= 5), 1'b1);
    rd_chk("rxirq_data", A_DATA, 8'h5A);
    repeat (2) @(posedge E_CLK);
    chk("rxirq_clear", IRQ_n, 1'b1);

    // transmit-idle interrupt, then reset in the middle of a byte
    bus_wr(A_CTRL, 8'h41);
    repeat (2) @(posedge E_CLK);
    chk("txirq", IRQ_n, 1'b0);
    rd_chk("txirq_stat", A_CTRL, 8'hC4);
    bus_wr(A_DATA, 8'h00);
    wait_fall("rst_mid_start");
    repeat (2) @(posedge E_CLK);
    chk("rst_mid_cnt_drv", CNT, 1'b0);
    chk("rst_mid_irq_busy", IRQ_n, 1'b1);
    #2 RESET_n = 1'b0;
    #1;
    chk("rst_mid_cnt", CNT, 1'b1);
    chk("rst_mid_sp", SP, 1'b1);
    chk("rst_mid_irq", IRQ_n, 1'b1);
    @(posedge E_CLK);
    RESET_n = 1'b1;
    rd_chk("rst_mid_stat", A_CTRL, 8'h04);
    rd_chk("rst_mid_div", A_DIV, 8'h07);
    rd_chk("rst_mid_lvl", A_LVL, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
